// File: rtl/coprocessor_mdu_wb_queue_if.sv
// MDU result / register-file writeback handshake bundle.
// The queue takes the slave view and the producer side takes the master view.
interface coprocessor_mdu_wb_queue_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic [4:0]            in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic [4:0]            in_flags;
    logic                  in_ready;
    logic                  wb_valid;
    logic [4:0]            wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_ready;

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        input  in_flags,
        output in_ready,
        output wb_valid,
        output wb_addr,
        output wb_data,
        input  wb_ready
    );

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        output in_flags,
        input  in_ready,
        input  wb_valid,
        input  wb_addr,
        input  wb_data,
        output wb_ready
    );
endinterface

// File: rtl/coprocessor_mdu_wb_queue.sv
// MDU writeback queue: circular result FIFO toward the register file,
// a pending-destination scoreboard for hazard checks and sticky MDU flags.
module coprocessor_mdu_wb_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    coprocessor_mdu_wb_queue_if.slave  wbq,
    input  logic                       issue_valid,
    input  logic [4:0]                 issue_rd,
    input  logic [4:0]                 rs1_q,
    input  logic [4:0]                 rs2_q,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic [4:0]                 flags_sticky,
    input  logic                       flags_clr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]            addr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pending_q, pending_d;
    logic [4:0]    flags_q, flags_d;
    logic          overflow_q, overflow_d;

    logic accept;
    logic push;
    logic pop;
    logic [4:0] flags_base;

    // Handshake outputs depend only on registered state (no bypass path).
    assign wbq.in_ready = (count_q < CW'(DEPTH));
    assign wbq.wb_valid = (count_q != '0);
    assign wbq.wb_addr  = addr_mem_q[rd_ptr_q];
    assign wbq.wb_data  = data_mem_q[rd_ptr_q];

    assign accept = wbq.in_valid && wbq.in_ready;
    assign push   = accept && (wbq.in_addr != 5'd0);
    assign pop    = wbq.wb_valid && wbq.wb_ready;

    assign count        = count_q;
    assign flags_sticky = flags_q;
    assign overflow_err = overflow_q;

    // An instruction issued this cycle already counts as a hazard.
    assign rs1_pending = pending_q[rs1_q] ||
                         (issue_valid && (issue_rd == rs1_q) &&
                          (rs1_q != 5'd0));
    assign rs2_pending = pending_q[rs2_q] ||
                         (issue_valid && (issue_rd == rs2_q) &&
                          (rs2_q != 5'd0));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear on retire first so a same-cycle re-issue of that register wins.
    always_comb begin
        pending_d = pending_q;
        if (pop) begin
            pending_d[wbq.wb_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        flags_base = flags_clr ? 5'd0 : flags_q;
        flags_d    = flags_base;
        if (accept) begin
            flags_d = {flags_base[4:1] | wbq.in_flags[4:1],
                       wbq.in_flags[0]};
        end
    end

    assign overflow_d = overflow_q || (wbq.in_valid && !wbq.in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            flags_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            flags_q    <= flags_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is left unreset; entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wbq.in_addr;
            data_mem_q[wr_ptr_q] <= wbq.in_data;
        end
    end
endmodule

// File: tb/tb_coprocessor_mdu_wb_queue.sv
// Bench for the MDU writeback queue: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_coprocessor_mdu_wb_queue;
    localparam int DW = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    logic issue_valid;
    logic [4:0] issue_rd;
    logic [4:0] rs1_q;
    logic [4:0] rs2_q;
    logic rs1_pending;
    logic rs2_pending;
    logic [4:0] flags_sticky;
    logic flags_clr;
    logic [$clog2(DEPTH):0] count;
    logic overflow_err;

    coprocessor_mdu_wb_queue_if #(.DATA_WIDTH(DW)) bus ();

    coprocessor_mdu_wb_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wbq          (bus),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1_q        (rs1_q),
        .rs2_q        (rs2_q),
        .rs1_pending  (rs1_pending),
        .rs2_pending  (rs2_pending),
        .flags_sticky (flags_sticky),
        .flags_clr    (flags_clr),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          iv;
        bit [4:0]    ia;
        bit [DW-1:0] id;
        bit [4:0]    ifl;
        bit          wr;
        bit          isv;
        bit [4:0]    ird;
        bit [4:0]    r1;
        bit [4:0]    r2;
        bit          fc;
        int          cnt;
        bit          wbv;
        bit [4:0]    wba;
        bit [DW-1:0] wbd;
        bit          rdy;
        bit          p1;
        bit          p2;
        bit [4:0]    fl;
        bit          ov;
    } vec_t;

    typedef struct {
        bit [4:0]    a;
        bit [DW-1:0] d;
    } ent_t;

    vec_t tab[$];
    ent_t mq[$];
    bit   mpend[32];
    bit [4:0] mfl;
    bit   mov;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h",
                     name, cyc, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.in_valid = v.iv;
        bus.in_addr = v.ia;
        bus.in_data = v.id;
        bus.in_flags = v.ifl;
        bus.wb_ready = v.wr;
        issue_valid = v.isv;
        issue_rd = v.ird;
        rs1_q = v.r1;
        rs2_q = v.r2;
        flags_clr = v.fc;
    endtask

    task automatic model_check();
        bit e_p1;
        bit e_p2;
        e_p1 = mpend[rs1_q] ||
               (issue_valid && issue_rd == rs1_q && rs1_q != 0);
        e_p2 = mpend[rs2_q] ||
               (issue_valid && issue_rd == rs2_q && rs2_q != 0);
        chk("m_count", DW'(count), DW'(mq.size()));
        chk("m_in_ready", DW'(bus.in_ready), DW'(mq.size() < DEPTH));
        chk("m_wb_valid", DW'(bus.wb_valid), DW'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_wb_addr", DW'(bus.wb_addr), DW'(mq[0].a));
            chk("m_wb_data", bus.wb_data, mq[0].d);
        end
        chk("m_rs1_pending", DW'(rs1_pending), DW'(e_p1));
        chk("m_rs2_pending", DW'(rs2_pending), DW'(e_p2));
        chk("m_flags", DW'(flags_sticky), DW'(mfl));
        chk("m_overflow", DW'(overflow_err), DW'(mov));
    endtask

    task automatic model_update();
        bit rdy;
        bit [4:0] base;
        if (rst) begin
            mq.delete();
            foreach (mpend[i]) mpend[i] = 1'b0;
            mfl = '0;
            mov = 1'b0;
        end else begin
            rdy = mq.size() < DEPTH;
            if (mq.size() != 0 && bus.wb_ready) begin
                mpend[mq[0].a] = 1'b0;
                void'(mq.pop_front());
            end
            if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1'b1;
            if (bus.in_valid && rdy) begin
                base = flags_clr ? 5'd0 : mfl;
                mfl = {base[4:1] | bus.in_flags[4:1], bus.in_flags[0]};
                if (bus.in_addr != 0)
                    mq.push_back('{a: bus.in_addr, d: bus.in_data});
            end else if (flags_clr) begin
                mfl = '0;
            end
            if (bus.in_valid && !rdy) mov = 1'b1;
        end
    endtask

    task automatic tab_check(input vec_t v);
        chk("t_count", DW'(count), DW'(v.cnt));
        chk("t_wb_valid", DW'(bus.wb_valid), DW'(v.wbv));
        if (v.wbv) begin
            chk("t_wb_addr", DW'(bus.wb_addr), DW'(v.wba));
            chk("t_wb_data", bus.wb_data, v.wbd);
        end
        chk("t_in_ready", DW'(bus.in_ready), DW'(v.rdy));
        chk("t_rs1_pending", DW'(rs1_pending), DW'(v.p1));
        chk("t_rs2_pending", DW'(rs2_pending), DW'(v.p2));
        chk("t_flags", DW'(flags_sticky), DW'(v.fl));
        chk("t_overflow", DW'(overflow_err), DW'(v.ov));
    endtask

    task automatic cycle(input bit use_tab, input vec_t v);
        @(negedge clk);
        model_check();
        if (use_tab) tab_check(v);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic row(input bit r, iv, input bit [4:0] ia,
                       input bit [DW-1:0] id, input bit [4:0] ifl,
                       input bit wr, isv, input bit [4:0] ird, r1, r2,
                       input bit fc, input int cnt, input bit wbv,
                       input bit [4:0] wba, input bit [DW-1:0] wbd,
                       input bit rdy, p1, p2, input bit [4:0] fl,
                       input bit ov);
        vec_t v;
        v = '{rst: r, iv: iv, ia: ia, id: id, ifl: ifl, wr: wr,
              isv: isv, ird: ird, r1: r1, r2: r2, fc: fc, cnt: cnt,
              wbv: wbv, wba: wba, wbd: wbd, rdy: rdy, p1: p1, p2: p2,
              fl: fl, ov: ov};
        tab.push_back(v);
    endtask

    initial begin
        vec_t z;
        vec_t rv;
        z = '{default: 0};
        z.rst = 1'b1;
        drive(z);
        mfl = '0;
        mov = 1'b0;
        foreach (mpend[i]) mpend[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // rst iv ia id fl wr isv ird r1 r2 fc | cnt wbv wba wbd rdy p1 p2 fl ov
        row(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,0);
        row(0,1,5,64'h1234,0,1, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,0);
        row(0,0,0,0,0,1, 0,0,0,0,0, 1,1,5,64'h1234,1,0,0,5'h00,0);
        row(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,0);
        row(0,1,1,64'h11,0,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,0);
        row(0,1,2,64'h22,0,0, 0,0,0,0,0, 1,1,1,64'h11,1,0,0,5'h00,0);
        row(0,1,3,64'h33,0,0, 0,0,0,0,0, 2,1,1,64'h11,1,0,0,5'h00,0);
        row(0,1,4,64'h44,0,0, 0,0,0,0,0, 3,1,1,64'h11,1,0,0,5'h00,0);
        row(0,1,9,64'h99,0,0, 0,0,0,0,0, 4,1,1,64'h11,0,0,0,5'h00,0);
        row(0,1,10,64'hAA,0,1, 0,0,0,0,0, 4,1,1,64'h11,0,0,0,5'h00,1);
        row(0,0,0,0,0,1, 0,0,0,0,0, 3,1,2,64'h22,1,0,0,5'h00,1);
        row(0,1,12,64'hCC,0,1, 0,0,0,0,0, 2,1,3,64'h33,1,0,0,5'h00,1);
        row(0,0,0,0,0,1, 0,0,0,0,0, 2,1,4,64'h44,1,0,0,5'h00,1);
        row(0,0,0,0,0,1, 0,0,0,0,0, 1,1,12,64'hCC,1,0,0,5'h00,1);
        row(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,1);
        row(0,0,0,0,0,0, 1,7,7,3,0, 0,0,0,0,1,1,0,5'h00,1);
        row(0,1,7,64'h77,0,0, 0,0,7,7,0, 0,0,0,0,1,1,1,5'h00,1);
        row(0,0,0,0,0,1, 1,7,7,0,0, 1,1,7,64'h77,1,1,0,5'h00,1);
        row(0,0,0,0,0,0, 0,0,7,0,0, 0,0,0,0,1,1,0,5'h00,1);
        row(0,1,7,64'h1,0,0, 0,0,7,0,0, 0,0,0,0,1,1,0,5'h00,1);
        row(0,0,0,0,0,1, 0,0,7,0,0, 1,1,7,64'h1,1,1,0,5'h00,1);
        row(0,0,0,0,0,0, 0,0,7,0,0, 0,0,0,0,1,0,0,5'h00,1);
        row(0,1,0,64'h5,5'b01000,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'h00,1);
        row(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'b01000,1);
        row(0,1,0,0,5'b00001,0, 0,0,0,0,0, 0,0,0,0,1,0,0,5'b01000,1);
        row(0,0,0,0,0,0, 0,0,0,0,1, 0,0,0,0,1,0,0,5'b01001,1);
        row(0,1,0,0,5'b10011,0, 0,0,0,0,1, 0,0,0,0,1,0,0,5'b00000,1);
        row(0,1,1,64'h1,0,0, 1,3,0,0,0, 0,0,0,0,1,0,0,5'b10011,1);
        row(0,1,2,64'h2,0,0, 1,4,3,0,0, 1,1,1,64'h1,1,1,0,5'b10010,1);
        row(0,1,5,64'h5,0,0, 0,0,4,3,0, 2,1,1,64'h1,1,1,1,5'b10010,1);
        row(1,1,6,64'h6,0,1, 1,8,3,4,0, 3,1,1,64'h1,1,1,1,5'b10010,1);
        row(0,0,0,0,0,0, 0,0,3,4,0, 0,0,0,0,1,0,0,5'b00000,0);

        foreach (tab[i]) begin
            drive(tab[i]);
            cycle(1'b1, tab[i]);
        end

        for (int n = 0; n < 3000; n++) begin
            int phase;
            phase = (n / 200) % 3;
            rv = '{default: 0};
            rv.rst = ($urandom_range(0, 149) == 0);
            rv.iv = ($urandom_range(0, 3) != 0);
            rv.ia = ($urandom_range(0, 5) == 0) ? 5'd0
                    : 5'($urandom_range(1, 31));
            rv.id = {32'($urandom), 32'($urandom)};
            rv.ifl = 5'($urandom_range(0, 31));
            if (phase == 0) rv.wr = ($urandom_range(0, 3) == 0);
            else if (phase == 1) rv.wr = ($urandom_range(0, 3) != 0);
            else rv.wr = $urandom_range(0, 1) != 0;
            rv.isv = $urandom_range(0, 1) != 0;
            rv.ird = 5'($urandom_range(0, 31));
            rv.r1 = 5'($urandom_range(0, 31));
            rv.r2 = 5'($urandom_range(0, 31));
            rv.fc = ($urandom_range(0, 15) == 0);
            drive(rv);
            cycle(1'b0, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coprocessor_mdu_wb_queue.md
COPROCESSOR_MDU_WB_QUEUE -- requirements
Module: coprocessor_mdu_wb_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of result data.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2): number of result-queue entries.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  MDU result valid (driven by the MDU register-write strobe).
REQ-006 in_addr  input  5  MDU destination register.
REQ-007 in_data  input  DATA_WIDTH  MDU result value.
REQ-008 in_flags  input  5  MDU status flags {invalid, div_zero, overflow, negative, zero}.
REQ-009 in_ready  output  1  queue can accept a result this cycle.
REQ-010 wb_valid  output  1  head entry presented to the register-file write port.
REQ-011 wb_addr  output  5  head entry destination.
REQ-012 wb_data  output  DATA_WIDTH  head entry value.
REQ-013 wb_ready  input  1  register file accepts the head entry.
REQ-014 issue_valid  input  1  an MDU instruction is issued this cycle.
REQ-015 issue_rd  input  5  destination of the issued instruction.
REQ-016 rs1_q, rs2_q  input  5 each  source registers to check for hazards.
REQ-017 rs1_pending, rs2_pending  output  1 each  queried register awaits an MDU writeback.
REQ-018 flags_sticky  output  5  OR-accumulation of accepted in_flags[4:1]; bit 0 is the zero flag of the last accepted result.
REQ-019 flags_clr  input  1  clears flags_sticky.
REQ-020 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-021 overflow_err  output  1  sticky: a result arrived while in_ready was low.

Function
REQ-022 Push = in_valid && in_ready && in_addr!=0; pop = wb_valid && wb_ready.
REQ-023 in_ready SHALL be (count < DEPTH), combinational from registered count only; it does not depend on wb_ready.
REQ-024 FIFO storage SHALL be circular, with read and write pointers wrapping from DEPTH-1 to 0.
REQ-025 Latency: a result pushed in cycle N SHALL appear on wb_* no earlier than cycle N+1; there is no same-cycle bypass.
REQ-026 wb_valid = (count != 0); wb_addr and wb_data SHALL hold steady while wb_valid is high and wb_ready is low.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-028 in_valid with in_addr==0 SHALL NOT enqueue; its flags SHALL still be accumulated.
REQ-029 in_valid while in_ready is low SHALL drop the result and set overflow_err; the queue contents SHALL be unchanged.
REQ-030 Scoreboard: 32 pending bits. issue_valid with issue_rd!=0 sets bit[issue_rd]; a pop clears bit[wb_addr]. If set and clear hit the same register in one cycle, set wins. Bit 0 is always 0.
REQ-031 rs1_pending = pending[rs1_q] || (issue_valid && issue_rd==rs1_q && rs1_q!=0); rs2_pending is formed likewise. Both are combinational.
REQ-032 flags_sticky updates on any accepted in_valid (including in_addr==0). flags_clr in the same cycle as an accept yields only the new flags.

Reset
REQ-033 When rst is high at a clock edge, the block SHALL zero count, both pointers, all pending bits, flags_sticky and overflow_err. Consequently wb_valid=0 and in_ready=1 in the following cycle. Reset overrides any concurrent push, pop or issue, and any in-flight entries are discarded.
REQ-034 Storage contents need no reset; wb_data is don't-care while wb_valid=0.

Verification
REQ-035 Reset, then push (addr 5, data 0x1234) with wb_ready=1 -> wb_valid=1 next cycle with wb_addr=5 and wb_data=0x1234; count returns to 0 one cycle later.
REQ-036 Hold wb_ready=0 and push 4 results -> count=4 and in_ready=0; a 5th in_valid -> overflow_err=1 and the queue is unchanged; then drain with wb_ready=1 -> results come out in FIFO order and the pointers wrap.
REQ-037 Full queue with wb_ready=1 and in_valid=1 -> no push (in_ready=0), one pop, count=3.
REQ-038 issue_rd=7, then query rs1_q=7 -> rs1_pending=1 (also in the issue cycle itself); pop of addr 7 in the same cycle as a new issue of 7 -> pending stays 1.
REQ-039 Push in_addr=0 with in_flags=5'b01000 -> count stays 0 and flags_sticky[3]=1; assert flags_clr -> flags_sticky=0.
REQ-040 Assert rst with 3 entries queued and pending bits set -> the next cycle shows count=0, wb_valid=0, all pending outputs 0, and overflow_err=0.
